// File: rtl/firebird7_in_gate1_ijtag_host_pkg.sv
// Shared types and width helpers for the gate1 IJTAG scan host.
package firebird7_in_gate1_ijtag_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_SHIFT,
      ST_UPDATE,
      ST_NETRST,
      ST_RESP
   } host_state_e;

   typedef enum logic {
      OP_SCAN     = 1'b0,
      OP_NETRESET = 1'b1
   } host_op_e;

   function automatic int LEN_W(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   function automatic int IDX_W(input int max_len);
      return (max_len > 1) ? $clog2(max_len) : 1;
   endfunction

endpackage

// File: rtl/firebird7_in_gate1_ijtag_host_shreg.sv
// Shift-out register (LSB leaves first) and bit-indexed capture register.
module firebird7_in_gate1_ijtag_host_shreg
   import firebird7_in_gate1_ijtag_host_pkg::*;
#(
   parameter int MAX_LEN = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  logic                      load_i,
   input  logic [MAX_LEN-1:0]        data_i,
   input  logic                      shift_i,
   input  logic                      cap_en_i,
   input  logic [IDX_W(MAX_LEN)-1:0] cap_idx_i,
   input  logic                      cap_bit_i,
   output logic                      sout_o,
   output logic [MAX_LEN-1:0]        cap_o
);

   logic [MAX_LEN-1:0] sh_q;
   logic [MAX_LEN-1:0] cap_q;

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_q  <= '0;
         cap_q <= '0;
      end else if (clear_i) begin
         sh_q  <= '0;
         cap_q <= '0;
      end else if (load_i) begin
         sh_q  <= data_i;
         cap_q <= '0;
      end else begin
         if (shift_i) sh_q <= sh_q >> 1;
         if (cap_en_i) cap_q[cap_idx_i] <= cap_bit_i;
      end
   end

   assign sout_o = sh_q[0];
   assign cap_o  = cap_q;

endmodule

// File: rtl/firebird7_in_gate1_ijtag_scan_host.sv
// IJTAG initiator: turns request words into Capture-Shift-Update or network-reset sequences.
module firebird7_in_gate1_ijtag_scan_host
   import firebird7_in_gate1_ijtag_host_pkg::*;
#(
   parameter int MAX_LEN    = 64,
   parameter int RST_CYCLES = 4
) (
   input  logic                      ijtag_tck,
   input  logic                      ijtag_reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_op,
   input  logic [LEN_W(MAX_LEN)-1:0] req_len,
   input  logic [MAX_LEN-1:0]        req_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [MAX_LEN-1:0]        rsp_data,
   output logic                      ijtag_to_reset,
   output logic                      ijtag_to_sel,
   output logic                      ijtag_to_ce,
   output logic                      ijtag_to_se,
   output logic                      ijtag_to_ue,
   output logic                      ijtag_to_si,
   input  logic                      ijtag_from_so
);

   localparam int LW  = LEN_W(MAX_LEN);
   localparam int IW  = IDX_W(MAX_LEN);
   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int CW  = (IW > RCW) ? IW : RCW;

   host_state_e   state_q;
   logic [LW-1:0] len_q;
   logic [CW-1:0] cnt_q;
   logic          req_ready_q, rsp_valid_q;
   logic          to_reset_q, sel_q, ce_q, se_q, ue_q, si_q;

   logic          accept, shift_last, rsp_hs, shift_en, sout;
   logic [LW-1:0] len_eff;

   assign accept     = (state_q == ST_IDLE) && req_valid && req_ready_q;
   assign len_eff    = (req_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : req_len;
   assign shift_last = (cnt_q == CW'(len_q - LW'(1)));
   assign rsp_hs     = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;
   assign shift_en   = ((state_q == ST_CAPTURE) && (len_q != '0)) ||
                       ((state_q == ST_SHIFT) && !shift_last);

   firebird7_in_gate1_ijtag_host_shreg #(.MAX_LEN(MAX_LEN)) u_shreg (
      .clk_i     (ijtag_tck),
      .rst_i     (ijtag_reset),
      .clear_i   (rsp_hs),
      .load_i    (accept),
      .data_i    (req_data),
      .shift_i   (shift_en),
      .cap_en_i  (state_q == ST_SHIFT),
      .cap_idx_i (IW'(cnt_q)),
      .cap_bit_i (ijtag_from_so),
      .sout_o    (sout),
      .cap_o     (rsp_data)
   );

   // Outputs are loaded with the value for the state being entered, so they line up with state_q.
   always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
      if (ijtag_reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         to_reset_q  <= 1'b0;
         sel_q       <= 1'b0;
         ce_q        <= 1'b0;
         se_q        <= 1'b0;
         ue_q        <= 1'b0;
         si_q        <= 1'b0;
      end else begin
         to_reset_q <= 1'b1;
         sel_q      <= 1'b0;
         ce_q       <= 1'b0;
         se_q       <= 1'b0;
         ue_q       <= 1'b0;
         si_q       <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               req_ready_q <= 1'b1;
               if (accept) begin
                  req_ready_q <= 1'b0;
                  len_q       <= len_eff;
                  cnt_q       <= '0;
                  if (host_op_e'(req_op) == OP_NETRESET) begin
                     state_q    <= ST_NETRST;
                     to_reset_q <= 1'b0;
                  end else begin
                     state_q <= ST_CAPTURE;
                     sel_q   <= 1'b1;
                     ce_q    <= 1'b1;
                  end
               end
            end
            ST_CAPTURE: begin
               sel_q <= 1'b1;
               if (len_q != '0) begin
                  state_q <= ST_SHIFT;
                  se_q    <= 1'b1;
                  si_q    <= sout;
               end else begin
                  state_q <= ST_UPDATE;
                  ue_q    <= 1'b1;
               end
            end
            ST_SHIFT: begin
               sel_q <= 1'b1;
               if (shift_last) begin
                  state_q <= ST_UPDATE;
                  ue_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  se_q  <= 1'b1;
                  si_q  <= sout;
               end
            end
            ST_UPDATE: state_q <= ST_RESP;
            ST_NETRST: begin
               if (cnt_q == CW'(RST_CYCLES - 1)) begin
                  state_q <= ST_RESP;
               end else begin
                  cnt_q      <= cnt_q + CW'(1);
                  to_reset_q <= 1'b0;
               end
            end
            ST_RESP: begin
               if (rsp_hs) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign ijtag_to_reset = to_reset_q;
   assign ijtag_to_sel   = sel_q;
   assign ijtag_to_ce    = ce_q;
   assign ijtag_to_se    = se_q;
   assign ijtag_to_ue    = ue_q;
   assign ijtag_to_si    = si_q;

endmodule
